// File: rtl/rv_mem_pkg.sv
// Shared state encoding, counter width and error-cause codes for the
// data-memory responder and its bench.
package rv_mem_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam int CNT_W = 3;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;

  // Misalignment is reported in preference to range when both apply.
  function automatic logic [1:0] err_cause(input logic misaligned, input logic out_of_range);
    if (misaligned) return ERR_ALIGN;
    if (out_of_range) return ERR_RANGE;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/rv_sram_sp.sv
// Single-port word array: synchronous write, combinational read, storage
// never reset.
module rv_sram_sp #(
  parameter int DPWIDTH  = 32,
  parameter int MEMDEPTH = 1024,
  parameter int IDXW     = (MEMDEPTH > 1) ? $clog2(MEMDEPTH) : 1
) (
  input  logic               clk,
  input  logic               we,
  input  logic [IDXW-1:0]    idx,
  input  logic [DPWIDTH-1:0] wdata,
  output logic [DPWIDTH-1:0] rdata
);

  logic [DPWIDTH-1:0] mem [MEMDEPTH];
  logic               in_range;

  // Guards non-power-of-two depths where idx can exceed the array.
  assign in_range = {1'b0, idx} < (IDXW + 1)'(MEMDEPTH);

  always_ff @(posedge clk) begin
    if (we && in_range) mem[idx] <= wdata;
  end

  assign rdata = in_range ? mem[idx] : '0;

endmodule

// File: rtl/rv_dmem_resp.sv
// Data-memory responder: accepts one request in IDLE, waits LATENCY cycles,
// then pulses mem_ready for one cycle with read data or an error flag.
module rv_dmem_resp
  import rv_mem_pkg::*;
#(
  parameter int DPWIDTH  = 32,
  parameter int MEMDEPTH = 1024,
  parameter int LATENCY  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [DPWIDTH-1:0] mem_addr,
  input  logic [DPWIDTH-1:0] mem_wdata,
  output logic [DPWIDTH-1:0] mem_rdata,
  output logic               mem_ready,
  output logic               mem_err,
  output logic               busy
);

  localparam int IDXW = (MEMDEPTH > 1) ? $clog2(MEMDEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DPWIDTH-1:0] req_addr;
  logic [DPWIDTH-1:0] req_wdata;
  logic               req_we;

  logic [DPWIDTH-1:0] acc_addr;
  logic [DPWIDTH-1:0] acc_word;
  logic               acc_we;
  logic [1:0]         acc_cause;
  logic               acc_bad;
  logic               enter_resp;
  logic               sram_we;
  logic [DPWIDTH-1:0] sram_rdata;

  // In IDLE the access being decided is the incoming one (needed when
  // LATENCY=0); afterwards it is the latched request.
  always_comb begin
    acc_addr   = (state == ST_IDLE) ? mem_addr : req_addr;
    acc_we     = (state == ST_IDLE) ? mem_we : req_we;
    acc_word   = acc_addr >> 2;
    acc_cause  = err_cause(acc_addr[1:0] != 2'b00, acc_word >= DPWIDTH'(MEMDEPTH));
    acc_bad    = (acc_cause != ERR_NONE);
    enter_resp = ((state == ST_IDLE) && mem_req && (LATENCY == 0)) ||
                 ((state == ST_WAIT) && (cnt == '0));
  end

  // Write commits on the edge ending RESP; a reset on that edge cancels it.
  assign sram_we = (state == ST_RESP) && req_we && !acc_bad && !rst;
  assign busy    = (state != ST_IDLE);

  rv_sram_sp #(
    .DPWIDTH (DPWIDTH),
    .MEMDEPTH(MEMDEPTH),
    .IDXW    (IDXW)
  ) u_sram (
    .clk  (clk),
    .we   (sram_we),
    .idx  (acc_word[IDXW-1:0]),
    .wdata(req_wdata),
    .rdata(sram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= enter_resp;
      mem_err   <= enter_resp && acc_bad;
      if (enter_resp) begin
        if (acc_bad) mem_rdata <= '0;
        else if (!acc_we) mem_rdata <= sram_rdata;
      end
      case (state)
        ST_IDLE: begin
          if (mem_req) state <= (LATENCY > 0) ? ST_WAIT : ST_RESP;
          cnt <= CNT_INIT;
        end
        ST_WAIT: begin
          if (cnt == '0) state <= ST_RESP;
          else cnt <= cnt - 1'b1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && mem_req) begin
      req_addr  <= mem_addr;
      req_wdata <= mem_wdata;
      req_we    <= mem_we;
    end
  end

endmodule

// File: tb/tb_rv_dmem_resp.sv
// Directed bench for rv_dmem_resp: one instance with LATENCY=2, one with
// LATENCY=0; a vector table plus hand-written multi-cycle sequences.
module tb_rv_dmem_resp;

  logic        clk, rst, req, we, sel;
  logic [31:0] addr, wdata;
  logic        req2, req0;
  logic [31:0] rdata2, rdata0;
  logic        ready2, ready0, err2, err0, busy2, busy0;
  logic        cur_ready, cur_err;
  logic [31:0] cur_rdata;

  int n_chk = 0;
  int n_pass = 0;

  assign req2 = req & sel;
  assign req0 = req & ~sel;
  assign cur_ready = sel ? ready2 : ready0;
  assign cur_err   = sel ? err2 : err0;
  assign cur_rdata = sel ? rdata2 : rdata0;

  rv_dmem_resp #(.DPWIDTH(32), .MEMDEPTH(1024), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .mem_req(req2), .mem_we(we), .mem_addr(addr),
    .mem_wdata(wdata), .mem_rdata(rdata2), .mem_ready(ready2), .mem_err(err2),
    .busy(busy2)
  );

  rv_dmem_resp #(.DPWIDTH(32), .MEMDEPTH(1024), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .mem_req(req0), .mem_we(we), .mem_addr(addr),
    .mem_wdata(wdata), .mem_rdata(rdata0), .mem_ready(ready0), .mem_err(err0),
    .busy(busy0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Called at a falling edge with the selected DUT idle. lat is the number of
  // rising edges from acceptance until ready is seen (-1 if never).
  task automatic txn(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] rd, output logic er);
    sel = s; we = w; addr = a; wdata = d; req = 1'b1;
    lat = -1; rd = '0; er = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      req = 1'b0;
      if (cur_ready === 1'b1) begin
        lat = n; rd = cur_rdata; er = cur_err;
        break;
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  int          lat;
  logic [31:0] rd;
  logic        er;
  int          pulses, bad_busy, bad_ready, bad_err, seen;

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0006, 32'h0,         32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b1, 32'h0000_1000, 32'h5555_5555, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0FFC, 32'h0,         32'h0BAD_F00D, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0002, 32'h2222_2222, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0};
    vecs[10] = '{1'b0, 32'h8000_0010, 32'h0,         32'h0000_0000, 1'b1};
    vecs[11] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};

    rst = 1'b1; req = 1'b0; we = 1'b0; sel = 1'b1; addr = '0; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready2", 32'(ready2), 32'd0);
    check("rst_err2", 32'(err2), 32'd0);
    check("rst_rdata2", rdata2, 32'd0);
    check("rst_busy2", 32'(busy2), 32'd0);
    check("rst_ready0", 32'(ready0), 32'd0);
    check("rst_busy0", 32'(busy0), 32'd0);

    for (int i = 0; i < 12; i++) begin
      txn(1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd, er);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'd3);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    txn(1'b0, 1'b1, 32'h0, 32'h0000_1234, lat, rd, er);
    check("l0_wr_lat", 32'(lat), 32'd1);
    check("l0_wr_err", 32'(er), 32'd0);
    txn(1'b0, 1'b0, 32'h0, 32'h0, lat, rd, er);
    check("l0_rd_lat", 32'(lat), 32'd1);
    check("l0_rd_rdata", rd, 32'h0000_1234);
    txn(1'b0, 1'b0, 32'h5, 32'h0, lat, rd, er);
    check("l0_mis_lat", 32'(lat), 32'd1);
    check("l0_mis_err", 32'(er), 32'd1);
    check("l0_mis_rdata", rd, 32'd0);

    // Request held high: one accept every LATENCY+2 cycles.
    sel = 1'b1; we = 1'b0; addr = 32'h10; req = 1'b1;
    pulses = 0; bad_busy = 0; bad_ready = 0; bad_err = 0;
    for (int c = 0; c < 20; c++) begin
      if (busy2 !== (c % 4 != 0)) bad_busy++;
      if (ready2 !== (c % 4 == 3)) bad_ready++;
      if (ready2 === 1'b1) pulses++;
      if (ready2 !== 1'b1 && err2 !== 1'b0) bad_err++;
      @(negedge clk);
    end
    req = 1'b0;
    check("b2b_pulses", 32'(pulses), 32'd5);
    check("b2b_busy_pattern", 32'(bad_busy), 32'd0);
    check("b2b_ready_pattern", 32'(bad_ready), 32'd0);
    check("b2b_err_idle", 32'(bad_err), 32'd0);
    check("b2b_rdata", rdata2, 32'hDEAD_BEEF);
    @(negedge clk);

    // Reset during WAIT discards a pending write.
    txn(1'b1, 1'b1, 32'h20, 32'h1357_2468, lat, rd, er);
    check("pre20_lat", 32'(lat), 32'd3);
    sel = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h0000_AAAA; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("rstw_busy_wait", 32'(busy2), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_busy_after", 32'(busy2), 32'd0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (ready2 === 1'b1) seen++;
      @(negedge clk);
    end
    check("rstw_no_ready", 32'(seen), 32'd0);
    txn(1'b1, 1'b0, 32'h20, 32'h0, lat, rd, er);
    check("rstw_rd20", rd, 32'h1357_2468);

    // Reset in the RESP cycle of a write: ready seen, write cancelled.
    txn(1'b1, 1'b1, 32'h24, 32'h0F0F_0F0F, lat, rd, er);
    check("pre24_lat", 32'(lat), 32'd3);
    sel = 1'b1; we = 1'b1; addr = 32'h24; wdata = 32'hF0F0_F0F0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstr_ready_resp", 32'(ready2), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstr_ready_after", 32'(ready2), 32'd0);
    check("rstr_busy_after", 32'(busy2), 32'd0);
    check("rstr_rdata_after", rdata2, 32'd0);
    txn(1'b1, 1'b0, 32'h24, 32'h0, lat, rd, er);
    check("rstr_rd24", rd, 32'h0F0F_0F0F);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
